truth_table_scanner: RTL and testbench
======================================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter SETTLE, default 1, cycles each 4-bit code is held on w_out before f_in is sampled (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a scan; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  cancels a scan in progress.
REQ-006 SHALL have port expect  input  16  golden truth table, bit i = expected f for code i; captured at start.
REQ-007 SHALL have port f_in  input  1  output of the downstream 4-input combinational function under test.
REQ-008 SHALL have port w_out  output  4  code driven to the downstream 4-to-16 decoder/function.
REQ-009 SHALL have port busy  output  1  high while scanning.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a full scan completes.
REQ-011 SHALL have port table_out  output  16  captured truth table, bit i = f_in sampled for code i.
REQ-012 SHALL have port ones_cnt  output  5  number of 1 bits captured (0..16).
REQ-013 SHALL have port match  output  1  table_out equals captured expect; valid from the done cycle on.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE, all outputs registered.
REQ-015 IDLE: start=1 at an edge SHALL enter SCAN, set busy=1, set w_out=0, set settle counter=0, clear table_out, ones_cnt and match, and capture expect.
REQ-016 SCAN: each code i SHALL be held on w_out for exactly SETTLE cycles; at the edge ending the SETTLE-th cycle, table_out[i] SHALL take f_in and ones_cnt SHALL increment by f_in.
REQ-017 SCAN: after sampling code i<15, w_out SHALL advance to i+1 with the settle counter reset; after sampling code 15, the FSM SHALL enter DONE; w_out SHALL not wrap during SCAN.
REQ-018 Busy duration SHALL be exactly 16*SETTLE cycles; start at edge k SHALL give busy=1 in cycles k+1..k+16*SETTLE.
REQ-019 DONE SHALL last one cycle with done=1, busy=0, w_out=0, and match=(final table == captured expect); the FSM SHALL then return to IDLE.
REQ-020 table_out, ones_cnt and match SHALL hold their values in IDLE until the next accepted start.
REQ-021 start SHALL be ignored in SCAN and DONE; start high in the DONE cycle SHALL NOT begin a scan, and the first accepted start SHALL be in IDLE.
REQ-022 abort=1 in SCAN SHALL return the FSM to IDLE at that edge with busy=0, w_out=0, no done pulse, match=0, and table_out/ones_cnt left partial.
REQ-023 abort in IDLE or DONE SHALL have no effect; abort and start both high in IDLE SHALL give abort priority, so no scan starts.
REQ-024 Changes to expect after capture SHALL NOT affect match.
REQ-025 ones_cnt SHALL equal the popcount of table_out at all times outside reset.

Reset
REQ-026 resetn=0 at an edge SHALL force IDLE, w_out=0, busy=0, done=0, table_out=0, ones_cnt=0, match=0 and clear the settle counter and captured expect, regardless of state, including mid-scan.
REQ-027 Reset SHALL take priority over start and abort.

Verification
REQ-028 SETTLE=1, f_in driven from a function with minterms {1,4,6,8,9,13,15}, expect=16'hA352, start pulse -> busy for 16 cycles, w_out steps 0..15 one per cycle, done pulse in cycle 17, table_out=16'hA352, ones_cnt=7, match=1.
REQ-029 Same stimulus with expect=16'hA353 -> table_out=16'hA352, ones_cnt=7, match=0.
REQ-030 SETTLE=3, f_in=1 constant -> each code held 3 cycles, busy 48 cycles, table_out=16'hFFFF, ones_cnt=16 (no overflow); f_in=0 gives 16'h0000, ones_cnt=0.
REQ-031 Abort asserted while w_out=5 -> next cycle busy=0, w_out=0, no done pulse, table_out bits 0..4 only, match=0; a following start gives a clean full scan.
REQ-032 resetn=0 while w_out=9 -> all outputs zero the next cycle; start asserted during reset is ignored; start after release scans normally.
REQ-033 start held high continuously -> back-to-back scans with exactly one idle cycle after each DONE; start pulses during SCAN have no effect.

Source files
------------

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: steps a 4-bit code through 0..15, captures f_in per code and compares against a golden table
module truth_table_scanner #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    input  logic        f_in,
    output logic [3:0]  w_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  ones_cnt,
    output logic        match
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n, w_n;
    logic [15:0] exp_r, exp_n, tbl_n;
    logic [4:0] ones_n;
    logic match_n, busy_n, done_n;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        w_n = w_out;
        exp_n = exp_r;
        tbl_n = table_out;
        ones_n = ones_cnt;
        match_n = match;
        busy_n = 1'b0;
        done_n = 1'b0;
        case (state)
            IDLE: if (start && !abort) begin
                state_n = SCAN;
                cnt_n = '0;
                w_n = '0;
                tbl_n = '0;
                ones_n = '0;
                match_n = 1'b0;
                exp_n = expected;
                busy_n = 1'b1;
            end
            SCAN: begin
                busy_n = 1'b1;
                if (abort) begin
                    state_n = IDLE;
                    busy_n = 1'b0;
                    w_n = '0;
                    cnt_n = '0;
                    match_n = 1'b0;
                end else if (cnt == 4'(SETTLE - 1)) begin
                    tbl_n[w_out] = f_in;
                    ones_n = ones_cnt + 5'(f_in);
                    cnt_n = '0;
                    // the last code's sample is folded into the match decision on the same edge
                    if (w_out == 4'd15) begin
                        state_n = DONE;
                        busy_n = 1'b0;
                        done_n = 1'b1;
                        w_n = '0;
                        match_n = (tbl_n == exp_r);
                    end else begin
                        w_n = w_out + 4'd1;
                    end
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt <= '0;
            w_out <= '0;
            exp_r <= '0;
            table_out <= '0;
            ones_cnt <= '0;
            match <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            w_out <= w_n;
            exp_r <= exp_n;
            table_out <= tbl_n;
            ones_cnt <= ones_n;
            match <= match_n;
            busy <= busy_n;
            done <= done_n;
        end
    end
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: vector table plus corner sequences, two instances (SETTLE=1 and SETTLE=3) observed through a selector
module tb_truth_table_scanner;
    logic clk = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0, sel = 1'b0;
    logic [15:0] expected = '0, func = '0;
    logic f1, f3, busy1, busy3, done1, done3, m1, m3;
    logic [3:0] w1, w3;
    logic [15:0] t1, t3;
    logic [4:0] o1, o3;
    logic [3:0] w;
    logic busy, done, m;
    logic [15:0] tbl;
    logic [4:0] ones;
    int n_tests = 0, n_fail = 0;

    typedef struct {
        logic sel;
        logic [15:0] func;
        logic [15:0] exp;
        logic [4:0] ones;
        logic match;
    } vec_t;
    typedef struct {
        logic [15:0] tbl;
        logic [4:0] ones;
        logic match;
    } res_t;
    res_t q[$];
    vec_t vecs[5];

    always #5 clk = ~clk;
    assign f1 = func[w1];
    assign f3 = func[w3];
    assign w = sel ? w3 : w1;
    assign busy = sel ? busy3 : busy1;
    assign done = sel ? done3 : done1;
    assign m = sel ? m3 : m1;
    assign tbl = sel ? t3 : t1;
    assign ones = sel ? o3 : o1;

    truth_table_scanner #(.SETTLE(1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort), .expected(expected), .f_in(f1),
        .w_out(w1), .busy(busy1), .done(done1), .table_out(t1), .ones_cnt(o1), .match(m1)
    );
    truth_table_scanner #(.SETTLE(3)) dut3 (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort), .expected(expected), .f_in(f3),
        .w_out(w3), .busy(busy3), .done(done3), .table_out(t3), .ones_cnt(o3), .match(m3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic pop_check();
        res_t r;
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: done seen with nothing queued");
        end else begin
            r = q.pop_front();
            check("table_out", tbl, r.tbl);
            check("ones_cnt", ones, r.ones);
            check("match", m, r.match);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy1 || busy3 || done1 || done3) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: timeout after %0d cycles", k);
        end
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no done within %0d cycles", name, k);
        end
    endtask

    task automatic wait_code(input logic [3:0] code);
        int k = 0;
        while (w !== code && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reach_code", w, code);
    endtask

    task automatic run(input vec_t v);
        int settle;
        wait_idle();
        sel = v.sel;
        func = v.func;
        expected = v.exp;
        settle = v.sel ? 3 : 1;
        start = 1'b1;
        q.push_back('{v.func, v.ones, v.match});
        @(negedge clk);
        start = 1'b0;
        expected = ~v.exp;
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < settle; s++) begin
                start = (i == 5 && s == 0);
                check("busy", busy, 1);
                check("w_out", w, i);
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("done", done, 1);
        check("busy_in_done", busy, 0);
        check("w_out_in_done", w, 0);
        pop_check();
        @(negedge clk);
        check("done_pulse_end", done, 0);
        check("match_hold", m, v.match);
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'hA352, 16'hA352, 5'd7, 1'b1};
        vecs[1] = '{1'b0, 16'hA352, 16'hA353, 5'd7, 1'b0};
        vecs[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 5'd16, 1'b1};
        vecs[3] = '{1'b1, 16'h0000, 16'h0000, 5'd0, 1'b1};
        vecs[4] = '{1'b0, 16'h8001, 16'h1234, 5'd2, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_w_out", w, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_table", tbl, 0);
        check("rst_ones", ones, 0);
        check("rst_match", m, 0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run(vecs[i]);

        wait_idle();
        sel = 1'b0;
        func = 16'hA352;
        expected = 16'hA352;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_code(4'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_w_out", w, 0);
        check("abort_done", done, 0);
        check("abort_table", tbl, 16'h0012);
        check("abort_ones", ones, 2);
        check("abort_match", m, 0);
        @(negedge clk);
        check("abort_no_done", done, 0);
        run(vecs[0]);

        wait_idle();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_code(4'd9);
        resetn = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("mid_rst_w_out", w, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_table", tbl, 0);
        check("mid_rst_ones", ones, 0);
        check("mid_rst_match", m, 0);
        @(negedge clk);
        check("rst_start_ignored", busy, 0);
        resetn = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", busy, 0);
        run(vecs[1]);

        wait_idle();
        sel = 1'b0;
        func = 16'hA352;
        expected = 16'hA352;
        start = 1'b1;
        q.push_back('{16'hA352, 5'd7, 1'b1});
        q.push_back('{16'hA352, 5'd7, 1'b1});
        @(negedge clk);
        wait_done("held_first");
        pop_check();
        @(negedge clk);
        check("held_idle_busy", busy, 0);
        check("held_idle_done", done, 0);
        @(negedge clk);
        check("held_restart_busy", busy, 1);
        check("held_restart_w_out", w, 0);
        wait_done("held_second");
        pop_check();
        start = 1'b0;

        wait_idle();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_prio_busy", busy, 0);
        check("idle_table_hold", tbl, 16'hA352);
        check("idle_match_hold", m, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
